// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/DIV unit with HI/LO registers.
// One radix-2 step per cycle, sign fix-up in a final cycle.

module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [2*W-1:0] prod;
  logic           neg_a;
  logic           neg_b;
  logic [2:0]     op_q;

  logic           accept;
  logic           go;
  logic           sgn_in;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  logic           is_div;
  logic           sgn_q;
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_diff;
  logic           q_bit;
  logic [2*W-1:0] step;

  logic           dz;
  logic           flip;
  logic [2*W-1:0] p_mul;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic [W-1:0]   a_orig;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  assign busy = (state != IDLE);

  // Request decode and operand magnitudes.
  always_comb begin
    accept = (state == IDLE) && start;
    go     = accept && !op[2];
    sgn_in = !op[0];
    a_neg  = sgn_in && a[W-1];
    b_neg  = sgn_in && b[W-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = CALC;
      CALC: if (cnt == CW'(W - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // One radix-2 step: prod is {acc_hi, multiplier} or {rem, quo}.
  always_comb begin
    is_div   = op_q[1];
    mul_sum  = {1'b0, prod[2*W-1:W]}
             + (prod[0] ? {1'b0, ma} : '0);
    div_sh   = {prod[2*W-1:W], prod[W-1]};
    div_diff = div_sh - {1'b0, mb};
    q_bit    = !div_diff[W];
    if (is_div) begin
      step = {q_bit ? div_diff[W-1:0] : div_sh[W-1:0],
              prod[W-2:0], q_bit};
    end else begin
      step = {mul_sum, prod[W-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero result selection.
  always_comb begin
    sgn_q  = !op_q[0];
    dz     = (mb == '0);
    flip   = sgn_q && (neg_a ^ neg_b);
    p_mul  = flip ? (~prod + 1'b1) : prod;
    q_fix  = flip ? (~prod[W-1:0] + 1'b1)
                  : prod[W-1:0];
    r_fix  = (sgn_q && neg_a)
           ? (~prod[2*W-1:W] + 1'b1)
           : prod[2*W-1:W];
    a_orig = neg_a ? (~ma + 1'b1) : ma;
    if (is_div && dz) begin
      fix_hi = a_orig;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = r_fix;
      fix_lo = q_fix;
    end else begin
      fix_hi = p_mul[2*W-1:W];
      fix_lo = p_mul[W-1:0];
    end
  end

  // Operand latch, iteration, HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      ma          <= '0;
      mb          <= '0;
      prod        <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      op_q        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            go: begin
              ma          <= a_mag;
              mb          <= b_mag;
              neg_a       <= a_neg;
              neg_b       <= b_neg;
              op_q        <= op;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              prod        <= op[1]
                           ? {{W{1'b0}}, a_mag}
                           : {{W{1'b0}}, b_mag};
            end
            accept && (op == OP_MTHI): hi <= a;
            accept && (op == OP_MTLO): lo <= a;
            default: ;
          endcase
        end
        CALC: begin
          prod <= step;
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= is_div && dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors, expected results queued
// at issue time and popped by a monitor on each done pulse.

module tb_mdu_iter;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_done: got done=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        chk("mon_hi", hi, e.hi);
        chk("mon_lo", lo, e.lo);
        chk("mon_dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int n = 0;
    int k = 0;
    while (!done && k < 100) begin
      if (busy) n++;
      k++;
      @(negedge clk);
    end
    chk({nm, "_seen"}, {31'd0, done}, 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string nm, input logic [2:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el,
                     input logic ed);
    sb.push_back('{eh, el, ed});
    issue(o, x, y);
    wait_done(nm, 33);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    run("mult_neg", MULT, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_m1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'h00000000, 32'h00000001, 1'b0);
    run("div_neg", DIV, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_negb", DIV, 32'd7, 32'hFFFFFFFE,
        32'h00000001, 32'hFFFFFFFD, 1'b0);
    run("divu", DIVU, 32'd7, 32'd2,
        32'd1, 32'd3, 1'b0);
    run("divu_z", DIVU, 32'd7, 32'd0,
        32'd7, 32'hFFFFFFFF, 1'b1);
    chk("dbz_held", {31'd0, div_by_zero}, 32'd1);

    sb.push_back('{32'd0, 32'd6, 1'b0});
    issue(MULT, 32'd2, 32'd3);
    chk("dbz_clr", {31'd0, div_by_zero}, 32'd0);
    wait_done("mult_after_z", 33);

    run("div_wrap", DIV, 32'h80000000, 32'hFFFFFFFF,
        32'h00000000, 32'h80000000, 1'b0);

    sb.push_back('{32'd0, 32'd6, 1'b0});
    issue(MULT, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    issue(DIV, 32'd9, 32'd3);
    wait_done("busy_ign", 28);
    repeat (40) @(negedge clk);
    chk("busy_ign_quiet", {31'd0, busy}, 32'd0);
    chk("busy_ign_hi", hi, 32'd0);
    chk("busy_ign_lo", lo, 32'd6);

    run("div_z_sgn", DIV, 32'hFFFFFFFB, 32'd0,
        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    issue(MULT, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (45) @(negedge clk);
    chk("abort_quiet", {31'd0, busy}, 32'd0);

    @(negedge clk);
    start = 1'b1;
    op    = MTHI;
    a     = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = MTLO;
    a  = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_done", {31'd0, done}, 32'd0);

    for (int i = 6; i < 8; i++) begin
      @(negedge clk);
      start = 1'b1;
      op    = 3'(i);
      a     = 32'h0;
      b     = 32'h0;
      @(negedge clk);
      start = 1'b0;
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_hi", hi, 32'h12345678);
      chk("nop_lo", lo, 32'h9ABCDEF0);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
